serial_adder_ctrl: RTL and testbench

- Bit-serial addition controller that time-multiplexes one full-adder cell over WIDTH clock cycles.
- Adds two WIDTH-bit operands plus carry-in, LSB first.
- Trades latency for area: one adder cell instead of a WIDTH-bit ripple chain.
- Sits between a requesting datapath (start/done handshake) and the shared full-adder cell, which it sequences.

---
 rtl/serial_adder_pkg.sv | 14 +
 rtl/serial_adder_ctrl_fa_cell.sv | 13 +
 rtl/serial_adder_ctrl.sv | 108 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// Purely combinational 1-bit full adder, the shared arithmetic cell.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: sequences one full-adder cell over WIDTH cycles, LSB first,
// with a start/done handshake towards the requesting datapath.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int unsigned     CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic             fa_s, fa_c;

    fa_cell u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (c_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_sh_d  = operand_a;
                    b_sh_d  = operand_b;
                    c_d     = carry_in;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                end
            end
            RUN: begin
                a_sh_d           = a_sh_q >> 1;
                b_sh_d           = b_sh_q >> 1;
                // Shift-then-overwrite keeps this legal for WIDTH=1 too.
                sum_d            = sum_q >> 1;
                sum_d[WIDTH-1]   = fa_s;
                c_d              = fa_c;
                if (cnt_q == LAST) begin
                    cout_d  = fa_c;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign sum       = sum_q;
    assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of serial_adder_ctrl at WIDTH 8, 1 and 13.
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  a8, b8, s8;
    logic        ci8, st8, bz8, dn8, co8;
    logic        a1, b1, s1, ci1, st1, bz1, dn1, co1;
    logic [12:0] a13, b13, s13;
    logic        ci13, st13, bz13, dn13, co13;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .operand_a(a8), .operand_b(b8),
        .carry_in(ci8), .busy(bz8), .done(dn8), .sum(s8), .carry_out(co8)
    );
    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(st1), .operand_a(a1), .operand_b(b1),
        .carry_in(ci1), .busy(bz1), .done(dn1), .sum(s1), .carry_out(co1)
    );
    serial_adder_ctrl #(.WIDTH(13)) dut13 (
        .clk(clk), .rst_n(rst_n), .start(st13), .operand_a(a13), .operand_b(b13),
        .carry_in(ci13), .busy(bz13), .done(dn13), .sum(s13), .carry_out(co13)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
    } vec_t;
    vec_t vecs[9];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic [63:0] a, input logic [63:0] b,
                         input logic ci, input logic st);
        case (sel)
            0: begin a8 = a[7:0]; b8 = b[7:0]; ci8 = ci; st8 = st; end
            1: begin a1 = a[0]; b1 = b[0]; ci1 = ci; st1 = st; end
            default: begin a13 = a[12:0]; b13 = b[12:0]; ci13 = ci; st13 = st; end
        endcase
    endtask

    task automatic sample(input int sel, output logic dn, output logic bz,
                          output logic [63:0] s, output logic co);
        case (sel)
            0: begin dn = dn8; bz = bz8; s = 64'(s8); co = co8; end
            1: begin dn = dn1; bz = bz1; s = 64'(s1); co = co1; end
            default: begin dn = dn13; bz = bz13; s = 64'(s13); co = co13; end
        endcase
    endtask

    // lat = edges after acceptance until done is seen; busy_n = busy samples up to done.
    task automatic run_op(input int sel, input logic [63:0] a, input logic [63:0] b,
                          input logic ci, input int poke, output int lat, output int busy_n,
                          output logic [63:0] s, output logic co);
        logic dn, bz;
        int   k;
        @(negedge clk);
        drive(sel, a, b, ci, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(sel, '0, '0, 1'b0, 1'b0);
        lat = -1;
        busy_n = 0;
        k = 0;
        while (k < 100) begin
            if (k == poke + 1) drive(sel, '0, '0, 1'b0, 1'b0);
            sample(sel, dn, bz, s, co);
            if (bz) busy_n++;
            if (dn) begin
                lat = k;
                break;
            end
            if (k == poke) drive(sel, 64'h11, 64'h22, 1'b1, 1'b1);
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        int          lat, busy_n, last, ndone, gap_bad;
        logic [63:0] s, prev_s, exp;
        logic        co, dn, bz;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[3] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
        vecs[4] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        vecs[8] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};

        drive(0, '0, '0, 1'b0, 1'b0);
        drive(1, '0, '0, 1'b0, 1'b0);
        drive(2, '0, '0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(bz8), 64'd0);
        check("rst_done", 64'(dn8), 64'd0);
        check("rst_sum", 64'(s8), 64'd0);
        check("rst_cout", 64'(co8), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_op(0, 64'(vecs[i].a), 64'(vecs[i].b), vecs[i].cin, -10, lat, busy_n, s, co);
            check($sformatf("v%0d_lat", i), 64'(lat), 64'd8);
            check($sformatf("v%0d_busy", i), 64'(busy_n), 64'd9);
            check($sformatf("v%0d_sum", i), s, 64'(vecs[i].s));
            check($sformatf("v%0d_cout", i), 64'(co), 64'(vecs[i].co));
            prev_s = s;
            @(negedge clk);
            sample(0, dn, bz, s, co);
            check($sformatf("v%0d_done_1cyc", i), 64'(dn), 64'd0);
            check($sformatf("v%0d_idle", i), 64'(bz), 64'd0);
            check($sformatf("v%0d_hold", i), s, prev_s);
        end

        // start raised during RUN is ignored, no second done
        run_op(0, 64'h5A, 64'h3C, 1'b0, 3, lat, busy_n, s, co);
        check("poke_lat", 64'(lat), 64'd8);
        check("poke_sum", {s[62:0], co}, {55'd0, 8'h96, 1'b0});
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (dn8) ndone++;
        end
        check("poke_no_second_done", 64'(ndone), 64'd0);
        check("poke_hold", 64'(s8), 64'h96);

        // start held high: one op per WIDTH+2 cycles
        @(negedge clk);
        drive(0, 64'h80, 64'h80, 1'b1, 1'b1);
        last = -100;
        ndone = 0;
        gap_bad = 0;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (dn8) begin
                if (last >= 0 && (k - last) != 10) gap_bad++;
                check($sformatf("held%0d_res", ndone), {55'd0, co8, s8}, {55'd0, 1'b1, 8'h01});
                last = k;
                ndone++;
            end
        end
        drive(0, '0, '0, 1'b0, 1'b0);
        check("held_ndone", 64'(ndone), 64'd4);
        check("held_gap", 64'(gap_bad), 64'd0);
        for (int k = 0; k < 20 && bz8; k++) @(negedge clk);
        check("held_drain", 64'(bz8), 64'd0);

        // asynchronous reset mid-RUN
        @(negedge clk);
        drive(0, 64'h5A, 64'h3C, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(0, '0, '0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(bz8), 64'd0);
        check("arst_done", 64'(dn8), 64'd0);
        check("arst_sum", 64'(s8), 64'd0);
        check("arst_cout", 64'(co8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (dn8 || bz8) ndone++;
        end
        check("arst_quiet", 64'(ndone), 64'd0);
        run_op(0, 64'h12, 64'h34, 1'b0, -10, lat, busy_n, s, co);
        check("arst_fresh", {s[62:0], co}, {55'd0, 8'h46, 1'b0});

        // WIDTH=1
        run_op(1, 64'd1, 64'd1, 1'b1, -10, lat, busy_n, s, co);
        check("w1_lat", 64'(lat), 64'd1);
        check("w1_sum", s, 64'd1);
        check("w1_cout", 64'(co), 64'd1);
        run_op(1, 64'd1, 64'd0, 1'b0, -10, lat, busy_n, s, co);
        check("w1_b", {s[62:0], co}, {63'd1, 1'b0});

        for (int i = 0; i < 1000; i++) begin
            logic [63:0] ra, rb;
            logic        rc;
            ra = 64'($urandom_range(255));
            rb = 64'($urandom_range(255));
            rc = 1'($urandom_range(1));
            exp = ra + rb + 64'(rc);
            run_op(0, ra, rb, rc, -10, lat, busy_n, s, co);
            check($sformatf("r8_%0d a=%0h b=%0h c=%0d", i, ra, rb, rc), {55'd0, co, s[7:0]}, exp);
        end
        for (int i = 0; i < 1000; i++) begin
            logic [63:0] ra, rb;
            logic        rc;
            ra = 64'($urandom_range(8191));
            rb = 64'($urandom_range(8191));
            rc = 1'($urandom_range(1));
            exp = ra + rb + 64'(rc);
            run_op(2, ra, rb, rc, -10, lat, busy_n, s, co);
            check($sformatf("r13_%0d a=%0h b=%0h c=%0d", i, ra, rb, rc), {50'd0, co, s[12:0]}, exp);
            if (i == 0) check("w13_lat", 64'(lat), 64'd13);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
